freq_synth: RTL

//  Square-wave synthesizer; the generating counterpart of the sensor frequency counter.

---
 rtl/freq_pkg.sv | 21 ++
 rtl/freq_nco_core.sv | 57 +++++
 rtl/freq_synth.sv | 125 ++++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// freq_pkg: shared types, defaults and helpers for the frequency synthesizer.
//   WINDOW_DEFAULT : gate window length in clk cycles (1 ms at 100 MHz)
//   state_t        : synthesizer state (IDLE = output parked low, RUN = toggling)
//   clamp_freq()   : saturates a requested frequency to the largest legal value
package freq_pkg;

  localparam int WINDOW_DEFAULT = 100000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Works on 64-bit operands so any FREQ_W up to 64 can share it; callers
  // zero-extend their operands and take the low bits of the result.
  function automatic logic [63:0] clamp_freq(input logic [63:0] f,
                                             input logic [63:0] max_f);
    return (f > max_f) ? max_f : f;
  endfunction

endpackage

// File: rtl/freq_nco_core.sv
// freq_nco_core: Bresenham-style accumulator that produces the square wave.
//   clk     in  1         system clock
//   rst     in  1         asynchronous active-high reset
//   step    in  FREQ_W+1  increment per cycle (2 * frequency)
//   clear   in  1         force acc and sig_out to 0 (window boundary / disabled)
//   run     in  1         accumulate and toggle; when low acc and sig_out stay 0
//   sig_out out 1         registered square wave
module freq_nco_core #(
  parameter int WINDOW = 100000,
  parameter int FREQ_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W:0]   step,
  input  logic              clear,
  input  logic              run,
  output logic              sig_out
);

  localparam logic [FREQ_W:0]   WIN_EXT = (FREQ_W+1)'(WINDOW);
  localparam logic [FREQ_W-1:0] WIN_LO  = FREQ_W'(WINDOW);

  logic [FREQ_W-1:0] acc_reg, acc_next;
  logic              sig_reg, sig_next;
  logic [FREQ_W:0]   sum;

  // The sum is one bit wider than acc so the compare never overflows.
  assign sum = {1'b0, acc_reg} + step;

  always_comb begin
    acc_next = acc_reg;
    sig_next = sig_reg;
    if (clear || !run) begin
      acc_next = '0;
      sig_next = 1'b0;
    end else if (sum >= WIN_EXT) begin
      // Result is below WINDOW, so modular arithmetic on the low bits is exact.
      acc_next = sum[FREQ_W-1:0] - WIN_LO;
      sig_next = ~sig_reg;
    end else begin
      acc_next = sum[FREQ_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      sig_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      sig_reg <= sig_next;
    end
  end

  assign sig_out = sig_reg;

endmodule

// File: rtl/freq_synth.sv
// freq_synth: square-wave synthesizer emitting exactly cur_freq rising edges
// per WINDOW-cycle gate window.
//   clk          in  1       system clock
//   rst          in  1       asynchronous active-high reset
//   en           in  1       run enable
//   freq_in      in  FREQ_W  requested edges per window
//   freq_load    in  1       strobe capturing freq_in into the pending slot
//   freq_busy    out 1       pending value not yet applied
//   freq_clamped out 1       pulse: last captured freq_in exceeded MAX_FREQ
//   cur_freq     out FREQ_W  frequency in effect for the current window
//   window_tick  out 1       pulse on the last cycle of each window
//   active       out 1       state == RUN
//   sig_out      out 1       synthesized square wave (registered)
module freq_synth
  import freq_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEFAULT,
  parameter int FREQ_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_load,
  output logic              freq_busy,
  output logic              freq_clamped,
  output logic [FREQ_W-1:0] cur_freq,
  output logic              window_tick,
  output logic              active,
  output logic              sig_out
);

  localparam int              CW       = $clog2(WINDOW);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WINDOW - 1);
  localparam logic [FREQ_W-1:0] MAX_FREQ = FREQ_W'((WINDOW - 1) / 2);

  state_t            state_reg, state_next;
  logic [CW-1:0]     win_cnt_reg, win_cnt_next;
  logic [FREQ_W-1:0] pend_freq_reg, pend_freq_next;
  logic [FREQ_W-1:0] cur_freq_reg, cur_freq_next;
  logic              busy_reg, busy_next;
  logic              clamped_reg, clamped_next;
  logic              tick;
  logic [63:0]       clamped_wide;

  // Gated by en so a window cannot end in a disabled cycle.
  assign tick = en && (win_cnt_reg == LAST_CNT);

  assign clamped_wide = clamp_freq(64'(freq_in), 64'(MAX_FREQ));

  // Window counter, load/pending and frequency update.
  always_comb begin
    win_cnt_next   = win_cnt_reg + CW'(1);
    pend_freq_next = pend_freq_reg;
    busy_next      = busy_reg;
    cur_freq_next  = cur_freq_reg;
    clamped_next   = freq_load && (freq_in > MAX_FREQ);

    if (!en || tick)
      win_cnt_next = '0;

    if (tick && busy_reg) begin
      cur_freq_next = pend_freq_reg;
      busy_next     = 1'b0;
    end

    // A load in the boundary cycle lands after the swap above, so it stays
    // pending until the following boundary.
    if (freq_load) begin
      pend_freq_next = clamped_wide[FREQ_W-1:0];
      busy_next      = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      win_cnt_reg   <= '0;
      pend_freq_reg <= '0;
      cur_freq_reg  <= '0;
      busy_reg      <= 1'b0;
      clamped_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      win_cnt_reg   <= win_cnt_next;
      pend_freq_reg <= pend_freq_next;
      cur_freq_reg  <= cur_freq_next;
      busy_reg      <= busy_next;
      clamped_reg   <= clamped_next;
    end
  end

  // Next-state logic: state changes only at a boundary or on disable.
  always_comb begin
    state_next = state_reg;
    if (!en)
      state_next = IDLE;
    else if (tick)
      state_next = (cur_freq_next == '0) ? IDLE : RUN;
  end

  // Output logic.
  always_comb begin
    active = (state_reg == RUN);
  end

  freq_nco_core #(
    .WINDOW (WINDOW),
    .FREQ_W (FREQ_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .step    ({cur_freq_reg, 1'b0}),
    .clear   (tick || !en),
    .run     (state_reg == RUN),
    .sig_out (sig_out)
  );

  assign freq_busy    = busy_reg;
  assign freq_clamped = clamped_reg;
  assign cur_freq     = cur_freq_reg;
  assign window_tick  = tick;

endmodule
